// File: rtl/ts_inj_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ts_inj_scheduler_pkg
// Shared definitions for the timestamp-domain injection scheduler:
//   - ts_state_e       : burst sequencer states (IDLE/ARMED/FIRE/GAP/DONE)
//   - SYNC_STAGES_MIN  : smallest legal synchronizer depth
//   - DIV_MIN          : smallest legal timestamp clock divide ratio
//   - div_is_legal()   : divide ratio must be even and >= DIV_MIN
//   - div_half()       : timestamp_int_clk cycles per ts_clk half period
// ---------------------------------------------------------------------------
package ts_inj_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FIRE  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } ts_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int DIV_MIN         = 2;

  function automatic bit div_is_legal(input int div);
    return (div >= DIV_MIN) && ((div % 2) == 0);
  endfunction

  function automatic int div_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/ts_divider_counter.sv
// ---------------------------------------------------------------------------
// ts_divider_counter
// Derives the chip timestamp clock (timestamp_int_clk / DIV, 50% duty) and
// keeps a reference timestamp counter that steps on every rising ts_clk.
//
// Ports
//   timestamp_int_clk  in   block clock
//   cpu_resetn         in   asynchronous active-low reset
//   i_enable           in   run divider/counter; low holds everything at 0
//   o_ts_clk           out  timestamp clock to the chip
//   o_tick             out  combinational: ts_clk rises at the next edge
//   o_ts_next          out  binary value the counter takes on at that edge
//   o_ts_value         out  registered timestamp (binary, or Gray-coded)
//   o_ts_overflow      out  1-cycle pulse together with the wrap to 0
//
// Build option: define TS_GRAY_OUT_EN to Gray-code o_ts_value. The Gray
// register is loaded from the same next-value as the binary counter, so the
// latency is identical; o_ts_next stays binary for comparisons.
// ---------------------------------------------------------------------------
module ts_divider_counter
  import ts_inj_scheduler_pkg::*;
#(
  parameter int TS_WIDTH = 10,
  parameter int DIV      = 2
) (
  input  logic                timestamp_int_clk,
  input  logic                cpu_resetn,
  input  logic                i_enable,
  output logic                o_ts_clk,
  output logic                o_tick,
  output logic [TS_WIDTH-1:0] o_ts_next,
  output logic [TS_WIDTH-1:0] o_ts_value,
  output logic                o_ts_overflow
);

  localparam int HALF = div_half(DIV);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(HALF - 1);

  logic [CW-1:0]       r_div_cnt;
  logic                r_ts_clk;
  logic [TS_WIDTH-1:0] r_ts_bin;
  logic                r_ovf;
  logic                w_toggle;

  assign w_toggle  = (r_div_cnt == DIV_LAST);
  // The tick is the cycle whose closing edge raises ts_clk.
  assign o_tick    = i_enable & w_toggle & ~r_ts_clk;
  assign o_ts_next = r_ts_bin + TS_WIDTH'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_div_cnt <= '0;
      r_ts_clk  <= 1'b0;
      r_ts_bin  <= '0;
      r_ovf     <= 1'b0;
    end else if (!i_enable) begin
      r_div_cnt <= '0;
      r_ts_clk  <= 1'b0;
      r_ts_bin  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_toggle) begin
        r_div_cnt <= '0;
        r_ts_clk  <= ~r_ts_clk;
      end else begin
        r_div_cnt <= r_div_cnt + CW'(1);
      end
      if (o_tick) r_ts_bin <= o_ts_next;
      r_ovf <= o_tick && (r_ts_bin == '1);
    end
  end

  assign o_ts_clk      = r_ts_clk;
  assign o_ts_overflow = r_ovf;

`ifdef TS_GRAY_OUT_EN
  logic [TS_WIDTH-1:0] r_ts_gray;

  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn)   r_ts_gray <= '0;
    else if (!i_enable) r_ts_gray <= '0;
    else if (o_tick)    r_ts_gray <= o_ts_next ^ (o_ts_next >> 1);
  end

  assign o_ts_value = r_ts_gray;
`else
  assign o_ts_value = r_ts_bin;
`endif

endmodule

// File: rtl/ts_inj_scheduler.sv
// ---------------------------------------------------------------------------
// ts_inj_scheduler
// Runs the chip timestamp clock/reference counter and schedules bursts of
// injection triggers aligned to it. A burst is requested by toggling
// req_toggle (system-clock domain) and completion is signalled by toggling
// ack_toggle.
//
// Ports
//   timestamp_int_clk  in   block clock
//   cpu_resetn         in   asynchronous active-low reset
//   cfg_enable         in   run ts clock/counter; low aborts a burst
//   cfg_align          in   0 = periodic shots, 1 = shot when ts == offset
//   cfg_offset         in   alignment value (align mode)
//   cfg_period         in   ticks between shots (immediate mode), 0 -> 1
//   cfg_count          in   shots per burst, 0 = continuous
//   req_toggle         in   each edge requests one burst
//   ack_toggle         out  toggles when a burst completes or aborts
//   busy               out  burst accepted and not yet acknowledged
//   ts_clk             out  timestamp clock, 50% duty
//   ts_value           out  reference timestamp
//   ts_overflow        out  pulse with the all-ones -> 0 wrap
//   inj_trigger        out  trigger, TRIG_LEN cycles per shot
//   trig_cnt           out  shots fired in current/last burst (saturating)
//
// Build option: TS_GRAY_OUT_EN Gray-codes ts_value (see ts_divider_counter).
// ---------------------------------------------------------------------------
module ts_inj_scheduler
  import ts_inj_scheduler_pkg::*;
#(
  parameter int TS_WIDTH    = 10,
  parameter int DIV         = 2,
  parameter int TRIG_LEN    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                timestamp_int_clk,
  input  logic                cpu_resetn,
  input  logic                cfg_enable,
  input  logic                cfg_align,
  input  logic [TS_WIDTH-1:0] cfg_offset,
  input  logic [TS_WIDTH-1:0] cfg_period,
  input  logic [7:0]          cfg_count,
  input  logic                req_toggle,
  output logic                ack_toggle,
  output logic                busy,
  output logic                ts_clk,
  output logic [TS_WIDTH-1:0] ts_value,
  output logic                ts_overflow,
  output logic                inj_trigger,
  output logic [7:0]          trig_cnt
);

  if (!div_is_legal(DIV) || (SYNC_STAGES < SYNC_STAGES_MIN)) begin : g_param_check
    $error("ts_inj_scheduler: DIV must be even >= 2 and SYNC_STAGES >= 2");
  end

  localparam int SW    = 3 + 2 * TS_WIDTH + 8;
  localparam int LEN_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(TRIG_LEN - 1);

  // ---- input synchronizers -------------------------------------------------
  // The cfg_* bus is synchronized bit-wise; that is only safe because the
  // fields are quasi-static and are latched once, at request acceptance,
  // which happens after req_toggle has passed through the same depth.
  logic [SW-1:0]       w_async;
  logic [SW-1:0]       w_synced;
  logic [SW-1:0]       r_sync [SYNC_STAGES];
  logic                w_req_s, w_en_s, w_align_s;
  logic [TS_WIDTH-1:0] w_offset_s, w_period_s;
  logic [7:0]          w_count_s;

  assign w_async = {req_toggle, cfg_enable, cfg_align, cfg_offset, cfg_period, cfg_count};

  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= w_async;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign {w_req_s, w_en_s, w_align_s, w_offset_s, w_period_s, w_count_s} = w_synced;

  // ---- timestamp divider / counter ----------------------------------------
  logic                w_tick;
  logic [TS_WIDTH-1:0] w_ts_next;

  ts_divider_counter #(
    .TS_WIDTH (TS_WIDTH),
    .DIV      (DIV)
  ) u_div (
    .timestamp_int_clk (timestamp_int_clk),
    .cpu_resetn        (cpu_resetn),
    .i_enable          (w_en_s),
    .o_ts_clk          (ts_clk),
    .o_tick            (w_tick),
    .o_ts_next         (w_ts_next),
    .o_ts_value        (ts_value),
    .o_ts_overflow     (ts_overflow)
  );

  // ---- burst sequencer -----------------------------------------------------
  ts_state_e           r_state, w_state_nx;
  logic                r_req_seen;
  logic                r_ack;
  logic                r_align;
  logic [TS_WIDTH-1:0] r_offset;
  logic [TS_WIDTH-1:0] r_period;
  logic [7:0]          r_count;
  logic [7:0]          r_trig_cnt;
  logic [LEN_W-1:0]    r_len_cnt;
  logic [TS_WIDTH-1:0] r_since;
  logic                w_accept, w_fire, w_period_due, w_qual;

  // r_since counts ticks after the last shot's tick, so the current tick
  // makes it r_since + 1. It saturates, so a due shot that was skipped
  // while FIRE was active still fires on the first tick seen in GAP.
  assign w_period_due = ({1'b0, r_since} + {{TS_WIDTH{1'b0}}, 1'b1}) >= {1'b0, r_period};
  assign w_qual = r_align ? (w_tick && (w_ts_next == r_offset))
                          : (w_tick && ((r_state == ST_ARMED) || w_period_due));

  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) r_state <= ST_IDLE;
    else             r_state <= w_state_nx;
  end

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_fire     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_s != r_req_seen) begin
          w_accept   = 1'b1;
          w_state_nx = w_en_s ? ST_ARMED : ST_DONE;
        end
      end
      ST_ARMED, ST_GAP: begin
        if (!w_en_s) begin
          w_state_nx = ST_DONE;
        end else if (w_qual) begin
          w_fire     = 1'b1;
          w_state_nx = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (!w_en_s) begin
          w_state_nx = ST_DONE;
        end else if (r_len_cnt == LEN_LAST) begin
          w_state_nx = ((r_count != 8'd0) && (r_trig_cnt == r_count)) ? ST_DONE : ST_GAP;
        end
      end
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_align    <= 1'b0;
      r_offset   <= '0;
      r_period   <= '0;
      r_count    <= '0;
      r_trig_cnt <= '0;
      r_len_cnt  <= '0;
      r_since    <= '0;
    end else begin
      if (w_accept) begin
        r_req_seen <= w_req_s;
        r_trig_cnt <= '0;
        r_align    <= w_align_s;
        r_offset   <= w_offset_s;
        r_period   <= (w_period_s == '0) ? TS_WIDTH'(1) : w_period_s;
        r_count    <= w_count_s;
      end
      if (w_fire) begin
        r_len_cnt <= '0;
        r_since   <= '0;
        if (r_trig_cnt != 8'hFF) r_trig_cnt <= r_trig_cnt + 8'd1;
      end else begin
        if (r_state == ST_FIRE) r_len_cnt <= r_len_cnt + LEN_W'(1);
        if (w_tick && ((r_state == ST_FIRE) || (r_state == ST_GAP)) && (r_since != '1))
          r_since <= r_since + TS_WIDTH'(1);
      end
      // Acknowledge on leaving DONE, in the same edge that drops busy.
      if (r_state == ST_DONE) r_ack <= ~r_ack;
    end
  end

  assign inj_trigger = (r_state == ST_FIRE);
  assign busy        = (r_state != ST_IDLE);
  assign ack_toggle  = r_ack;
  assign trig_cnt    = r_trig_cnt;

endmodule

// File: tb/tb_ts_inj_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ts_inj_scheduler
// Directed bench for ts_inj_scheduler with TS_WIDTH=4, DIV=2, TRIG_LEN=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ts_inj_scheduler;

  localparam int TS_W = 4;
  localparam int DIV  = 2;
  localparam int TL   = 4;
  localparam int SS   = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            cfg_enable = 1'b0;
  logic            cfg_align = 1'b0;
  logic [TS_W-1:0] cfg_offset = '0;
  logic [TS_W-1:0] cfg_period = '0;
  logic [7:0]      cfg_count = '0;
  logic            req = 1'b0;
  logic            ack, busy, ts_clk, ts_ovf, inj;
  logic [TS_W-1:0] ts_value;
  logic [7:0]      trig_cnt;

  always #5 clk = ~clk;

  ts_inj_scheduler #(
    .TS_WIDTH    (TS_W),
    .DIV         (DIV),
    .TRIG_LEN    (TL),
    .SYNC_STAGES (SS)
  ) dut (
    .timestamp_int_clk (clk),
    .cpu_resetn        (rstn),
    .cfg_enable        (cfg_enable),
    .cfg_align         (cfg_align),
    .cfg_offset        (cfg_offset),
    .cfg_period        (cfg_period),
    .cfg_count         (cfg_count),
    .req_toggle        (req),
    .ack_toggle        (ack),
    .busy              (busy),
    .ts_clk            (ts_clk),
    .ts_value          (ts_value),
    .ts_overflow       (ts_ovf),
    .inj_trigger       (inj),
    .trig_cnt          (trig_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Expected ts_value encoding for a binary count.
  function automatic logic [TS_W-1:0] ts_exp(input int bin);
    logic [TS_W-1:0] b;
    b = bin[TS_W-1:0];
`ifdef TS_GRAY_OUT_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  // Burst observation results.
  int rise_at [8];
  int val_at  [8];
  int n_rise;
  int bad_width;
  bit timed_out;

  // Watch one burst: record trigger rises, pulse widths, stop when busy
  // falls after having been high.
  task automatic run_burst(input int budget);
    bit seen_busy = 1'b0;
    bit prev = 1'b0;
    int w = 0;
    n_rise = 0;
    bad_width = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 8; i++) begin rise_at[i] = 0; val_at[i] = 0; end
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (inj && !prev) begin
        if (n_rise < 8) begin rise_at[n_rise] = c; val_at[n_rise] = int'(ts_value); end
        n_rise++;
        check("trig_cnt_at_rise", trig_cnt, n_rise);
      end
      if (inj) w++;
      else begin
        if (prev && (w != TL)) bad_width++;
        w = 0;
      end
      prev = inj;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got_it;
    int lat;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_ts_clk", ts_clk, 0);
    check("rst_ts_value", ts_value, 0);
    check("rst_ts_overflow", ts_ovf, 0);
    check("rst_inj_trigger", inj, 0);
    check("rst_trig_cnt", trig_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("disabled_ts_clk", ts_clk, 0);

    // ---- enable: ts_clk period 2, ts_value counts, overflow on 15->0 ----
    // Enable passes 2 sync stages, so the first ts_clk rise (ts_value=1)
    // appears at the 3rd sampled cycle, then ts_clk alternates every cycle.
    cfg_enable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      bit e_clk;
      int e_v;
      @(negedge clk);
      e_clk = (k >= 3) && (((k - 3) % 2) == 0);
      e_v   = (k >= 3) ? ((((k - 3) / 2) + 1) % 16) : 0;
      check("en_ts_clk", ts_clk, e_clk);
      check("en_ts_value", ts_value, ts_exp(e_v));
      check("en_ts_overflow", ts_ovf, (e_clk && (e_v == 0)) ? 1 : 0);
    end

    // ---- immediate, period 3, count 3 ----
    cfg_align = 1'b0; cfg_period = 4'd3; cfg_count = 8'd3;
    settle();
    req = ~req;
    run_burst(300);
    check("imm_timeout", timed_out, 0);
    check("imm_shots", n_rise, 3);
    check("imm_gap_1", rise_at[1] - rise_at[0], 6);
    check("imm_gap_2", rise_at[2] - rise_at[1], 6);
    check("imm_width", bad_width, 0);
    check("imm_trig_cnt", trig_cnt, 3);
    check("imm_ack", ack, req);
    check("imm_busy", busy, 0);

    // ---- align, offset 5, count 2 ----
    cfg_align = 1'b1; cfg_offset = 4'd5; cfg_count = 8'd2;
    settle();
    req = ~req;
    run_burst(300);
    check("aln_timeout", timed_out, 0);
    check("aln_shots", n_rise, 2);
    check("aln_gap", rise_at[1] - rise_at[0], 32);
    check("aln_val_0", val_at[0], ts_exp(5));
    check("aln_val_1", val_at[1], ts_exp(5));
    check("aln_width", bad_width, 0);
    check("aln_ack", ack, req);
    check("aln_busy", busy, 0);

    // ---- skip rule: period 1, ticks during FIRE are dropped ----
    cfg_align = 1'b0; cfg_period = 4'd1; cfg_count = 8'd3;
    settle();
    req = ~req;
    run_burst(300);
    check("skip_timeout", timed_out, 0);
    check("skip_shots", n_rise, 3);
    check("skip_gap_1", rise_at[1] - rise_at[0], 6);
    check("skip_gap_2", rise_at[2] - rise_at[1], 6);
    check("skip_width", bad_width, 0);
    check("skip_ack", ack, req);

    // ---- period 0 behaves as period 1 ----
    cfg_period = 4'd0; cfg_count = 8'd2;
    settle();
    req = ~req;
    run_burst(300);
    check("p0_timeout", timed_out, 0);
    check("p0_shots", n_rise, 2);
    check("p0_gap", rise_at[1] - rise_at[0], 6);
    check("p0_trig_cnt", trig_cnt, 2);

    // ---- abort continuous burst during the 2nd pulse ----
    cfg_period = 4'd2; cfg_count = 8'd0;
    settle();
    req = ~req;
    begin
      bit prev = 1'b0;
      int seen = 0;
      got_it = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (inj && !prev) seen++;
        prev = inj;
        if (seen == 2) begin got_it = 1'b1; break; end
      end
    end
    check("abt_second_shot", got_it, 1);
    check("abt_trig_cnt", trig_cnt, 2);
    cfg_enable = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      lat = c;
      if (!inj) break;
    end
    // 2 sync stages, then one edge to leave FIRE.
    check("abt_latency", lat, SS + 1);
    check("abt_ts_value", ts_value, 0);
    check("abt_ts_clk", ts_clk, 0);
    got_it = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!busy) begin got_it = 1'b1; break; end
    end
    check("abt_busy_drop", got_it, 1);
    check("abt_ack", ack, req);

    // ---- request while disabled: immediately done, no shots ----
    cfg_count = 8'd3;
    settle();
    req = ~req;
    run_burst(30);
    check("dis_timeout", timed_out, 0);
    check("dis_shots", n_rise, 0);
    check("dis_trig_cnt", trig_cnt, 0);
    check("dis_ack", ack, req);

    // ---- reset mid-burst: abandoned, nothing acknowledged ----
    cfg_enable = 1'b1; cfg_period = 4'd1; cfg_count = 8'd0;
    settle();
    req = ~req;
    got_it = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (inj) begin got_it = 1'b1; break; end
    end
    check("rmb_running", got_it, 1);
    rstn = 1'b0;
    req  = 1'b0;
    @(negedge clk);
    check("rmb_inj", inj, 0);
    check("rmb_busy", busy, 0);
    check("rmb_trig_cnt", trig_cnt, 0);
    check("rmb_ack", ack, 0);
    check("rmb_ts_value", ts_value, 0);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    check("rmb_idle_busy", busy, 0);
    check("rmb_idle_inj", inj, 0);
    check("rmb_idle_ack", ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
